// File: rtl/rv_soc_apb_pkg.sv
// rtl/rv_soc_apb_pkg.sv - shared APB initiator types and PPROT bit constants
package rv_soc_apb_pkg;

    // Transfer phases of the APB initiator FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // PPROT bit positions, usable as masks when building cmd_prot.
    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/rv_soc_apb_initiator.sv
// rtl/rv_soc_apb_initiator.sv - single-outstanding APB initiator with optional wait timeout
//
// Ports:
//   PCLK, PRESET             clock and synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_addr, cmd_write, cmd_wdata,
//                            cmd_strb, cmd_prot carry the transfer request
//   rsp_valid/rsp_ready      response handshake; rsp_rdata, rsp_err, rsp_timeout
//   PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB   registered APB requester outputs
//   PRDATA, PREADY, PSLVERR  APB completer inputs
module rv_soc_apb_initiator
    import rv_soc_apb_pkg::*;
#(
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [2:0]              PPROT,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    // A zero-width counter is illegal, so TIMEOUT=0 keeps a 1-bit counter that never moves.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    apb_state_t    state;
    logic [CW-1:0] wait_cnt;

    // Only one transfer in flight: a new command waits until the previous response drained.
    assign cmd_ready = !PRESET && (state == IDLE) && !rsp_valid;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PPROT       <= '0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state    <= SETUP;
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        PADDR    <= cmd_addr;
                        PWRITE   <= cmd_write;
                        PPROT    <= cmd_prot;
                        PWDATA   <= cmd_wdata;
                        // Reads drive no byte lanes.
                        PSTRB    <= cmd_write ? cmd_strb : '0;
                        wait_cnt <= '0;
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end

                ACCESS: begin
                    // PREADY wins over the timeout when both land in the same cycle.
                    if (PREADY) begin
                        state       <= IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                    end else if (TIMEOUT > 0) begin
                        if (wait_cnt == TIMEOUT_CNT) begin
                            state       <= IDLE;
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_soc_apb_initiator.md
RV_SOC_APB_INITIATOR -- requirements
Module: rv_soc_apb_initiator

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 8: APB address width.
REQ-002 SHALL have parameter PDATA_SIZE, default 32: APB data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 0: maximum number of ACCESS wait cycles; 0 disables the timeout.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 PCLK  input  1  clock; all state updates on the rising edge.
REQ-006 PRESET  input  1  synchronous active-high reset.
REQ-007 cmd_valid  input  1, and cmd_ready  output  1: command handshake.
REQ-008 cmd_addr  input  PADDR_SIZE; cmd_write  input  1; cmd_wdata  input  PDATA_SIZE; cmd_strb  input  PDATA_SIZE/8; cmd_prot  input  3.
REQ-009 rsp_valid  output  1, and rsp_ready  input  1: response handshake.
REQ-010 rsp_rdata  output  PDATA_SIZE; rsp_err  output  1; rsp_timeout  output  1.
REQ-011 PSEL, PENABLE, PWRITE  output  1; PPROT  output  3; PADDR  output  PADDR_SIZE; PWDATA  output  PDATA_SIZE; PSTRB  output  PDATA_SIZE/8.
REQ-012 PRDATA  input  PDATA_SIZE; PREADY  input  1; PSLVERR  input  1.

Function
REQ-013 SHALL implement an FSM with three states, IDLE, SETUP and ACCESS; every APB output SHALL be a registered output.
REQ-014 cmd_ready SHALL be 1 only when the state is IDLE and rsp_valid is 0.
REQ-015 When cmd_valid and cmd_ready are both 1 in cycle N, the FSM SHALL move to SETUP, and the capture SHALL be as follows:
- cycle N+1: PSEL=1, PENABLE=0;
- PADDR, PWRITE and PPROT SHALL take the captured command fields;
- PWDATA SHALL take cmd_wdata.
REQ-016 For a read, PSTRB SHALL be all zeros; for a write, PSTRB SHALL equal cmd_strb.
REQ-017 SETUP SHALL always move to ACCESS after one cycle, with PSEL=1 and PENABLE=1.
REQ-018 PADDR, PWRITE, PPROT, PWDATA and PSTRB SHALL stay stable from SETUP until the transfer ends.
REQ-019 In ACCESS with PREADY=1, the transfer SHALL complete, and the next cycle SHALL have:
- PSEL=0 and PENABLE=0, with the state back in IDLE;
- rsp_valid=1 and rsp_err=PSLVERR;
- rsp_timeout=0;
- rsp_rdata=PRDATA for a read, or 0 for a write.
REQ-020 Minimum latency SHALL be 3 cycles: accept at N, rsp_valid at N+3 when PREADY=1 at N+2.
REQ-021 rsp_valid and all rsp_* fields SHALL hold unchanged until rsp_ready=1.
REQ-022 rsp_valid SHALL clear in the cycle after the rsp_valid&rsp_ready handshake; a new command SHALL be accepted no earlier than that cycle.
REQ-023 When TIMEOUT>0, a wait counter of width $clog2(TIMEOUT+1) SHALL clear on SETUP and increment every ACCESS cycle that has PREADY=0.
REQ-024 When TIMEOUT>0 and the counter equals TIMEOUT with PREADY=0, the transfer SHALL abort, and the next cycle SHALL have:
- PSEL=0 and PENABLE=0, with the state back in IDLE;
- rsp_valid=1 and rsp_err=1;
- rsp_timeout=1;
- rsp_rdata=0.
REQ-025 If PREADY=1 in the same cycle the counter reaches TIMEOUT, the transfer SHALL complete normally, with no timeout.
REQ-026 When TIMEOUT=0, the module SHALL wait for PREADY indefinitely, and rsp_timeout SHALL be constant 0.
REQ-027 PRDATA and PSLVERR SHALL be sampled only in ACCESS with PREADY=1.
REQ-028 PREADY while PSEL=0 SHALL be ignored.

Reset
REQ-029 On PRESET=1, the following SHALL apply at the next edge:
- state=IDLE;
- PSEL, PENABLE and PWRITE=0;
- PADDR, PWDATA, PSTRB and PPROT=0;
- rsp_valid, rsp_err and rsp_timeout=0;
- rsp_rdata=0 and the counter=0.
REQ-030 cmd_ready SHALL be 0 while PRESET=1 and SHALL become 1 in the first cycle after PRESET is released.
REQ-031 Reset asserted during SETUP or ACCESS SHALL abandon the transfer without producing any response.

Structure
REQ-032 A shared package rv_soc_apb_pkg SHALL hold the FSM state typedef (IDLE, SETUP, ACCESS) and the PPROT bit constants (privileged, non-secure, instruction).
REQ-033 The block SHALL be a single module with no sub-module, since the timeout counter is inline logic.

Verification
REQ-034 Read, PREADY held at 1, slave returning 0xDEADBEEF -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Write to address 0x40, data 0x12345678, strb 0x3, PREADY low for 2 ACCESS cycles -> PSTRB=0x3 stable throughout, rsp_valid at N+5, rsp_rdata=0.
REQ-036 Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0.
REQ-037 TIMEOUT=4, PREADY never asserted -> abort after 4 wait cycles with rsp_err=1 and rsp_timeout=1. A second run with PREADY=1 on the 4th wait cycle -> normal completion.
REQ-038 rsp_ready held at 0 for 5 cycles with cmd_valid=1 -> cmd_ready=0 and the response stable. Separately, PRESET=1 during ACCESS -> PSEL=0 next cycle and no rsp_valid.
